ifid_skid_reg: RTL and testbench
================================

Name: ifid_skid_reg

Overview:
Parametrised successor to the IF/ID pipeline register. It carries PC, instruction and branch-prediction bit from fetch to decode over a valid/ready handshake. A one-entry skid buffer keeps in_ready registered, so decode back-pressure never forms a combinational path back into fetch. It adds flush with NOP-bubble insertion, a valid bit, and a saturating stall-cycle counter for performance monitoring.

Parameters:
XLEN, 64, PC width in bits
ILEN, 32, instruction width in bits
NOP_INSN, 32'h0000_0013, encoding driven on out_insn when out_valid=0 (addi x0,x0,0)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  kill all held entries (branch mispredict / trap)
in_valid  in  1  fetch presents a beat
in_ready  out  1  register can accept a beat; registered output
in_pc  in  XLEN  PC of fetched instruction
in_insn  in  ILEN  fetched instruction
in_pred_taken  in  1  fetch predicted taken
out_valid  out  1  decode-side beat valid
out_ready  in  1  decode accepts beat
out_pc  out  XLEN  PC to decode
out_insn  out  ILEN  instruction to decode; NOP_INSN when out_valid=0
out_pred_taken  out  1  prediction bit to decode; 0 when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high, sampled only on the rising edge of clk.
- Storage: main entry (drives outputs) and skid entry. Each entry holds {pc, insn, pred_taken, valid}.
- Accept: in_fire = in_valid & in_ready. Deliver: out_fire = out_valid & out_ready.
- in_ready = ~skid.valid, taken directly from a flop.
- States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- EMPTY: in_fire -> load main -> ONE. Latency is one cycle: the beat is on the outputs the cycle after acceptance.
- ONE:
  - in_fire & out_fire -> main takes new beat, stay ONE.
  - in_fire & ~out_fire -> new beat goes to skid -> FULL.
  - ~in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL (in_ready=0, no accept):
  - out_fire -> skid moves to main, skid cleared -> ONE.
  - Otherwise hold; main payload stays stable while out_valid & ~out_ready.
- Ordering is strictly FIFO. No beat is dropped or duplicated except on flush.
- flush (priority over everything except rst):
  - Next cycle both entries are invalid, state EMPTY, in_ready=1.
  - A beat presented with in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as delivered (decode owns it).
- Payload when main invalid: out_insn=NOP_INSN, out_pred_taken=0, out_pc holds its last value (0 after reset).
- Reset values: out_valid=0, in_ready=1, out_pc=0, out_insn=NOP_INSN, out_pred_taken=0, stall_cnt=0, skid cleared.
- rst while FULL or ONE discards all entries; identical result to reset from idle.
- rst and flush together: rst result.
- stall_cnt:
  - +1 each cycle out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush; cleared only by rst.
- No $display or simulation-only side effects in RTL.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSN constant.
  - Default XLEN/ILEN.
  - Packed typedef if_id_payload_t {pc, insn, pred_taken}, reused by later stage registers.
- One natural sub-module: pipe_skid_entry, a single payload+valid holding register with load/clear, instantiated twice (main, skid).
- Counter stays inline.

Test Plan:
- rst=1 two cycles then release -> out_valid=0, in_ready=1, out_insn=32'h13, out_pc=0, stall_cnt=0.
- Stream pc=0x1000,0x1004,0x1008 with out_ready=1 -> each appears one cycle later, in order, in_ready stays 1.
- Accept 0x2000, then 0x2004 with out_ready=0 -> FULL, in_ready=0. Hold 5 cycles: out_pc=0x2000 stable, stall_cnt=5. Release -> 0x2000 then 0x2004 delivered, in_ready=1.
- FULL state with flush=1 and in_valid=1 (pc 0x3000) -> next cycle out_valid=0, out_insn=NOP, in_ready=1; 0x3000 never appears.
- CNT_W=4, out_ready=0 for 20 cycles with a valid beat -> stall_cnt saturates at 15; flush keeps 15, rst clears to 0.
- rst asserted in the same cycle as in_fire and flush in state ONE -> next cycle reset values; accepted beat lost.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared fetch/decode pipeline types and constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipe_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;

    // addi x0,x0,0: presented to decode whenever no real beat is held.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Default-width fetch->decode payload, reused by later stage registers.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] insn;
        logic                pred_taken;
    } if_id_payload_t;

    // Occupancy of a two-entry skid register (main entry, skid entry).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ifid_skid_reg_if.sv
// Fetch->decode handshake bundle: fetch beat in, decode beat out.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready valid-ready pairs.
interface ifid_skid_reg_if #(
    parameter int XLEN = pipe_pkg::XLEN_DEF,
    parameter int ILEN = pipe_pkg::ILEN_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_insn;
    logic            in_pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_insn;
    logic            out_pred_taken;

    // Environment side: fetch producer plus decode consumer.
    modport master (
        output in_valid, in_pc, in_insn, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_pc, out_insn, out_pred_taken
    );

    // Stage register side.
    modport slave (
        input  in_valid, in_pc, in_insn, in_pred_taken, out_ready,
        output in_ready, out_valid, out_pc, out_insn, out_pred_taken
    );
endinterface

// File: rtl/pipe_skid_entry.sv
// One payload+valid holding register with load and clear (clear keeps payload).
// Latency: one cycle from load to q/vld.
// Backpressure: none; load has priority over clear.
module pipe_skid_entry #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         vld
);
    logic [W-1:0] dat_q, dat_d;
    logic         vld_q, vld_d;

    // Next entry contents: load captures a beat, clear only drops the valid bit.
    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (load) begin
            dat_d = d;
            vld_d = 1'b1;
        end else if (clear) begin
            vld_d = 1'b0;
        end
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign q   = dat_q;
    assign vld = vld_q;
endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID stage register with one-entry skid buffer, flush and stall counter.
// Latency: one cycle from in_fire to out_valid.
// Backpressure: in_ready is a flop, low only while the skid entry is occupied.
module ifid_skid_reg
    import pipe_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter logic [ILEN-1:0] NOP_INSN = ILEN'(pipe_pkg::NOP_INSN),
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    ifid_skid_reg_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
        logic            pred_taken;
    } payload_t;

    localparam int              PW      = $bits(payload_t);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    payload_t    in_pay, main_q, skid_q, main_d;
    logic        main_vld, skid_vld;
    logic        main_load, main_clear, main_sel_skid;
    logic        skid_load, skid_clear;
    logic        in_fire, out_fire;
    logic        in_ready_q, in_ready_d;
    logic        skid_vld_next;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    skid_state_e state;

    assign in_pay  = '{pc: bus.in_pc, insn: bus.in_insn, pred_taken: bus.in_pred_taken};
    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = main_vld & bus.out_ready;

    // Occupancy decoded from the two entry valid bits.
    always_comb begin
        state = ST_EMPTY;
        if (skid_vld)      state = ST_FULL;
        else if (main_vld) state = ST_ONE;
    end

    // Entry steering: flush drops both entries; otherwise keep strict FIFO order.
    always_comb begin
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) main_load = 1'b1;
                end
                ST_ONE: begin
                    if (in_fire && out_fire) main_load  = 1'b1;
                    else if (in_fire)        skid_load  = 1'b1;
                    else if (out_fire)       main_clear = 1'b1;
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clear    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        main_d = main_sel_skid ? skid_q : in_pay;
    end

    pipe_skid_entry #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q),
        .vld   (main_vld)
    );

    pipe_skid_entry #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pay),
        .q     (skid_q),
        .vld   (skid_vld)
    );

    // in_ready mirrors next-cycle skid emptiness so it can come straight off a flop.
    always_comb begin
        skid_vld_next = skid_load | (skid_vld & ~skid_clear);
        in_ready_d    = ~skid_vld_next;
    end

    // Stall counter: decode holding back a valid beat, saturating, ignores flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld && !bus.out_ready && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Control and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = main_vld;
    assign bus.out_pc         = main_q.pc;
    assign bus.out_insn       = main_vld ? main_q.insn : NOP_INSN;
    assign bus.out_pred_taken = main_vld & main_q.pred_taken;
    assign stall_cnt          = stall_cnt_q;
endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed bench for ifid_skid_reg with a queue-based reference model.
// Latency: checks every negedge against the model, plus literal spot checks.
// Backpressure: exercised via out_ready holds, FULL, flush and reset.
module tb_ifid_skid_reg;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    ifid_skid_reg_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    ifid_skid_reg #(.XLEN(XLEN), .ILEN(ILEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] insn_of(input logic [63:0] pc);
        return {pc[15:0], 16'h0233};
    endfunction

    // Reference model: a queue of held beats, at most two deep.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
        logic        pred;
    } beat_t;

    beat_t       mq[$];
    logic [63:0] m_last_pc = '0;
    int          m_cnt     = 0;
    bit          m_init    = 0;
    bit          seen_3000 = 0;
    bit          seen_5004 = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_last_pc = '0;
            m_cnt     = 0;
            m_init    = 1;
        end else if (m_init) begin
            bit of, inf;
            beat_t b;
            if (mq.size() > 0 && !bus.out_ready && m_cnt < (1 << CNT_W) - 1)
                m_cnt++;
            of  = (mq.size() > 0) && bus.out_ready;
            inf = bus.in_valid && (mq.size() < 2);
            if (mq.size() > 0) m_last_pc = mq[0].pc;
            if (flush) begin
                mq.delete();
            end else begin
                if (of) void'(mq.pop_front());
                if (inf) begin
                    b.pc   = bus.in_pc;
                    b.insn = bus.in_insn;
                    b.pred = bus.in_pred_taken;
                    mq.push_back(b);
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_init) begin
            bit has;
            has = mq.size() > 0;
            chk("out_valid", bus.out_valid, has);
            chk("in_ready", bus.in_ready, mq.size() < 2);
            chk("out_pc", bus.out_pc, has ? mq[0].pc : m_last_pc);
            chk("out_insn", bus.out_insn, has ? mq[0].insn : 32'h13);
            chk("out_pred", bus.out_pred_taken, has ? mq[0].pred : 1'b0);
            chk("stall_cnt", stall_cnt, m_cnt);
            if (bus.out_valid && bus.out_pc == 64'h3000) seen_3000 = 1;
            if (bus.out_valid && bus.out_pc == 64'h5004) seen_5004 = 1;
        end
    end

    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [63:0] pc, input logic ordy);
        rst               = r;
        flush             = f;
        bus.in_valid      = iv;
        bus.in_pc         = pc;
        bus.in_insn       = insn_of(pc);
        bus.in_pred_taken = iv & pc[2];
        bus.out_ready     = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset for two cycles.
        cyc(1, 0, 0, 64'h0, 0);
        cyc(1, 0, 0, 64'h0, 0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_insn", bus.out_insn, 32'h13);
        chk("rst_pc", bus.out_pc, 64'h0);
        chk("rst_cnt", stall_cnt, 4'd0);

        // Streaming with decode always ready.
        cyc(0, 0, 1, 64'h1000, 1);
        chk("s0_pc", bus.out_pc, 64'h1000);
        chk("s0_valid", bus.out_valid, 1'b1);
        cyc(0, 0, 1, 64'h1004, 1);
        chk("s1_pc", bus.out_pc, 64'h1004);
        chk("s1_pred", bus.out_pred_taken, 1'b1);
        chk("s1_ready", bus.in_ready, 1'b1);
        cyc(0, 0, 1, 64'h1008, 1);
        chk("s2_pc", bus.out_pc, 64'h1008);
        chk("s2_insn", bus.out_insn, 32'h1008_0233);
        cyc(0, 0, 0, 64'h0, 1);
        chk("s_drain_valid", bus.out_valid, 1'b0);
        chk("s_drain_pc_hold", bus.out_pc, 64'h1008);

        // Fill to FULL and hold decode back.
        cyc(0, 0, 1, 64'h2000, 0);
        cyc(0, 0, 1, 64'h2004, 0);
        chk("full_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 64'h0, 0);
        chk("hold_pc", bus.out_pc, 64'h2000);
        chk("hold_cnt", stall_cnt, 4'd5);
        cyc(0, 0, 0, 64'h0, 1);
        chk("rel_pc", bus.out_pc, 64'h2004);
        chk("rel_ready", bus.in_ready, 1'b1);
        cyc(0, 0, 0, 64'h0, 1);
        chk("rel_empty", bus.out_valid, 1'b0);

        // Flush while FULL with a beat offered.
        cyc(0, 0, 1, 64'h3100, 0);
        cyc(0, 0, 1, 64'h3104, 0);
        cyc(0, 1, 1, 64'h3000, 0);
        chk("fl_valid", bus.out_valid, 1'b0);
        chk("fl_insn", bus.out_insn, 32'h13);
        chk("fl_ready", bus.in_ready, 1'b1);
        chk("fl_cnt", stall_cnt, 4'd7);
        cyc(0, 0, 0, 64'h0, 1);
        cyc(0, 0, 0, 64'h0, 1);

        // Saturation of the stall counter, kept by flush, cleared by reset.
        cyc(0, 0, 1, 64'h4000, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 64'h0, 0);
        chk("sat_cnt", stall_cnt, 4'd15);
        cyc(0, 1, 0, 64'h0, 0);
        chk("sat_flush_cnt", stall_cnt, 4'd15);
        cyc(1, 0, 0, 64'h0, 0);
        chk("sat_rst_cnt", stall_cnt, 4'd0);

        // Reset + flush + accept together in ONE.
        cyc(0, 0, 1, 64'h5000, 0);
        chk("one_pc", bus.out_pc, 64'h5000);
        cyc(1, 1, 1, 64'h5004, 0);
        chk("rf_valid", bus.out_valid, 1'b0);
        chk("rf_ready", bus.in_ready, 1'b1);
        chk("rf_pc", bus.out_pc, 64'h0);
        chk("rf_insn", bus.out_insn, 32'h13);
        chk("rf_pred", bus.out_pred_taken, 1'b0);
        chk("rf_cnt", stall_cnt, 4'd0);
        cyc(0, 0, 0, 64'h0, 1);
        cyc(0, 0, 0, 64'h0, 1);

        chk("never_3000", seen_3000, 1'b0);
        chk("never_5004", seen_5004, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
